// File: rtl/mbox_store_buffer.sv
// rtl/mbox_store_buffer.sv - posted-write store buffer between Mbox dmem port and memory bus
// In-order FIFO of doubleword stores with youngest-match load forwarding and overlap conflict detection.
module mbox_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic [AW-1:0]              st_addr,
  input  logic [DW-1:0]              st_data,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hit,
  output logic [DW-1:0]              ld_data,
  output logic                       ld_conflict,
  output logic                       mem_valid,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_data,
  input  logic                       mem_ready,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic enq;
  logic deq;

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign st_ready  = (count_q != CW'(DEPTH));
  assign mem_valid = !empty;
  assign mem_addr  = addr_q[head_q];
  assign mem_data  = data_q[head_q];

  assign enq = st_valid && st_ready;
  assign deq = mem_valid && mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + 1'b1;
      if (deq) head_q <= head_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload needs no reset: validity is tracked solely by head/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

  logic          found;
  logic          exact;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;
  logic [AW-1:0] d_fwd;
  logic [AW-1:0] d_bwd;

  // Walk oldest to youngest so the last overlapping entry wins.
  always_comb begin
    found    = 1'b0;
    exact    = 1'b0;
    fwd_data = '0;
    idx      = '0;
    d_fwd    = '0;
    d_bwd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx   = head_q + PW'(i);
      d_fwd = ld_addr - addr_q[idx];
      d_bwd = addr_q[idx] - ld_addr;
      if ((CW'(i) < count_q) && ((d_fwd < AW'(8)) || (d_bwd < AW'(8)))) begin
        found    = 1'b1;
        exact    = (addr_q[idx] == ld_addr);
        fwd_data = data_q[idx];
      end
    end
  end

  assign ld_hit      = ld_valid && found && exact;
  assign ld_conflict = ld_valid && found && !exact;
  assign ld_data     = ld_hit ? fwd_data : '0;

endmodule

// File: tb/tb_mbox_store_buffer.sv
// tb/tb_mbox_store_buffer.sv - directed self-checking bench for mbox_store_buffer
module tb_mbox_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [63:0] ld_addr;
  logic        ld_hit;
  logic [63:0] ld_data;
  logic        ld_conflict;
  logic        mem_valid;
  logic [63:0] mem_addr;
  logic [63:0] mem_data;
  logic        mem_ready;
  logic        empty;
  logic [2:0]  count;

  int checks;
  int failures;

  mbox_store_buffer #(.DEPTH(4), .AW(64), .DW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .ld_conflict(ld_conflict),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    st_valid  = 1'b0;
    mem_ready = 1'b1;
    while (!empty && n < 10) begin
      tick();
      n++;
    end
    mem_ready = 1'b0;
    check("drain_empty", empty, 1'b1);
  endtask

  function automatic logic [63:0] dval(input logic [63:0] a);
    return 64'hDA7A_0000_0000_0000 | a;
  endfunction

  localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DB = 64'h5555_6666_7777_8888;
  localparam logic [63:0] DC = 64'h9999_AAAA_BBBB_CCCC;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: asynchronous reset mid-cycle with a pending entry
    store(64'h8, 64'h1234);
    check("pre_reset_count", count, 3'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_st_ready", st_ready, 1'b1);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 3'd0);
    check("rst_ld_hit", ld_hit, 1'b0);
    check("rst_ld_conflict", ld_conflict, 1'b0);
    check("rst_ld_data", ld_data, 64'h0);
    tick();
    rst_n = 1'b1;

    // 2: fill, then a refused fifth store
    for (int i = 0; i < 4; i++) store(64'h10 + 64'(8 * i), dval(64'h10 + 64'(8 * i)));
    check("fill_count", count, 3'd4);
    check("fill_st_ready", st_ready, 1'b0);
    check("fill_mem_valid", mem_valid, 1'b1);
    store(64'h30, 64'hBAD);
    check("fifth_count", count, 3'd4);
    check("fifth_mem_addr_held", mem_addr, 64'h10);

    // 3: in-order drain
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_addr", mem_addr, 64'h10 + 64'(8 * i));
      check("drain_data", mem_data, dval(64'h10 + 64'(8 * i)));
      tick();
    end
    mem_ready = 1'b0;
    check("drain4_empty", empty, 1'b1);
    check("drain4_mem_valid", mem_valid, 1'b0);

    // 4: full buffer refuses store despite dequeue; wrapped slot next cycle
    for (int i = 0; i < 4; i++) store(64'h100 + 64'(8 * i), dval(64'h100 + 64'(8 * i)));
    mem_ready = 1'b1;
    st_valid = 1'b1; st_addr = 64'h200; st_data = dval(64'h200);
    check("full_refuse_ready", st_ready, 1'b0);
    tick();
    check("after_refuse_count", count, 3'd3);
    check("wrap_st_ready", st_ready, 1'b1);
    tick();
    st_valid = 1'b0;
    check("simul_count", count, 3'd3);
    check("wrap_head_addr", mem_addr, 64'h110);
    tick();
    check("wrap_addr1", mem_addr, 64'h118);
    tick();
    check("wrap_addr2", mem_addr, 64'h200);
    check("wrap_data2", mem_data, dval(64'h200));
    drain();

    // count==1 with simultaneous enqueue and dequeue stays non-empty
    store(64'h300, dval(64'h300));
    mem_ready = 1'b1;
    store(64'h308, dval(64'h308));
    mem_ready = 1'b0;
    check("c1_simul_empty", empty, 1'b0);
    check("c1_simul_count", count, 3'd1);
    check("c1_simul_addr", mem_addr, 64'h308);
    drain();

    // 5: forwarding from youngest exact match
    store(64'h40, DA);
    store(64'h40, DB);
    ld_valid = 1'b1;
    ld_addr = 64'h40; #1;
    check("fwd_hit", ld_hit, 1'b1);
    check("fwd_data", ld_data, DB);
    check("fwd_no_conflict", ld_conflict, 1'b0);
    ld_addr = 64'h44; #1;
    check("fwd44_conflict", ld_conflict, 1'b1);
    check("fwd44_hit", ld_hit, 1'b0);
    ld_addr = 64'h48; #1;
    check("fwd48_hit", ld_hit, 1'b0);
    check("fwd48_conflict", ld_conflict, 1'b0);
    check("fwd48_data", ld_data, 64'h0);
    ld_addr = 64'h39; #1;
    check("fwd39_conflict", ld_conflict, 1'b1);
    ld_addr = 64'h38; #1;
    check("fwd38_conflict", ld_conflict, 1'b0);
    ld_addr = 64'h40; ld_valid = 1'b0; #1;
    check("fwd_novalid_hit", ld_hit, 1'b0);
    check("fwd_novalid_data", ld_data, 64'h0);
    drain();

    // 6: youngest overlap is inexact -> conflict even though an older entry matches
    store(64'h40, DA);
    store(64'h43, DC);
    ld_valid = 1'b1; ld_addr = 64'h40;
    mem_ready = 1'b1; #1;
    check("young_conflict", ld_conflict, 1'b1);
    check("young_hit", ld_hit, 1'b0);
    ld_valid = 1'b0;
    drain();

    // address wraparound overlap and dequeuing head still searched
    store(64'hFFFF_FFFF_FFFF_FFFC, DC);
    ld_valid = 1'b1; ld_addr = 64'h0;
    mem_ready = 1'b1; #1;
    check("wrap_overlap_conflict", ld_conflict, 1'b1);
    ld_addr = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    check("deq_head_hit", ld_hit, 1'b1);
    check("deq_head_data", ld_data, DC);
    ld_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
